// File: rtl/ram_fifo_fwft.sv
// First-word-fall-through FIFO on an inferred simple dual-port RAM with a
// two-entry skid output stage, registered occupancy flags and a synchronous flush.
module ram_fifo_fwft #(
  parameter int ADDR  = 12,
  parameter int DATA  = 10,
  parameter int AFULL = 2**ADDR - 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [DATA-1:0] wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [DATA-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [ADDR:0]   level,
  output logic            empty,
  output logic            full,
  output logic            almost_full
);

  localparam int              DEPTH   = 2**ADDR;
  localparam logic [ADDR:0]   DEPTH_L = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   AFULL_L = (ADDR+1)'(AFULL);
  localparam logic [ADDR:0]   ONE_L   = (ADDR+1)'(1);
  localparam logic [ADDR:0]   ZERO_L  = (ADDR+1)'(0);
  localparam logic [ADDR-1:0] PTR_ONE = ADDR'(1);
  localparam logic [ADDR-1:0] PTR_ZERO = ADDR'(0);
  localparam logic [DATA-1:0] DATA_ZERO = DATA'(0);

  logic [DATA-1:0] mem_q [DEPTH];
  logic [DATA-1:0] ram_rd_q;
  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   ram_count_q, ram_count_d, level_q, level_d;
  logic            pend_q, pend_d;
  logic [1:0]      occ_q, occ_d;
  logic [DATA-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
  logic            wr_ready_q, wr_ready_d, empty_q, empty_d;
  logic            full_q, full_d, afull_q, afull_d;
  logic            wr_fire_s, pop_s, rd_issue_s;
  logic [2:0]      post_occ_s;
  logic [1:0]      land_idx_s;

  // A RAM read is only issued if its word is guaranteed a free skid entry when it lands.
  always_comb begin
    wr_fire_s  = wr_valid & wr_ready_q & ~flush;
    pop_s      = (occ_q != 2'd0) & rd_ready & ~flush;
    post_occ_s = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop_s};
    land_idx_s = occ_q - {1'b0, pop_s};
    rd_issue_s = (ram_count_q != ZERO_L) & (post_occ_s < 3'd2) & ~flush;
  end

  // Next-state logic; flush overrides every same-cycle write, pop and landing read.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    pend_d      = pend_q;
    occ_d       = occ_q;
    skid0_d     = skid0_q;
    skid1_d     = skid1_q;
    level_d     = level_q;
    wr_ready_d  = wr_ready_q;
    empty_d     = empty_q;
    full_d      = full_q;
    afull_d     = afull_q;
    if (flush) begin
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      ram_count_d = ZERO_L;
      pend_d      = 1'b0;
      occ_d       = 2'd0;
      skid0_d     = DATA_ZERO;
      skid1_d     = DATA_ZERO;
      level_d     = ZERO_L;
      wr_ready_d  = 1'b1;
      empty_d     = 1'b1;
      full_d      = 1'b0;
      afull_d     = 1'b0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_issue_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_fire_s, rd_issue_s})
        2'b10:   ram_count_d = ram_count_q + ONE_L;
        2'b01:   ram_count_d = ram_count_q - ONE_L;
        default: ram_count_d = ram_count_q;
      endcase
      pend_d = rd_issue_s;
      occ_d  = post_occ_s[1:0];
      // Pop shifts entry 1 down first; a landing word then takes the first free entry.
      if (pop_s) begin
        skid0_d = skid1_q;
      end else begin
        skid0_d = skid0_q;
      end
      if (pend_q) begin
        if (land_idx_s == 2'd0) begin
          skid0_d = ram_rd_q;
        end else begin
          skid1_d = ram_rd_q;
        end
      end else begin
        skid1_d = skid1_q;
      end
      case ({wr_fire_s, pop_s})
        2'b10:   level_d = level_q + ONE_L;
        2'b01:   level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
      wr_ready_d = (level_d != DEPTH_L);
      full_d     = (level_d == DEPTH_L);
      empty_d    = (level_d == ZERO_L);
      afull_d    = (level_d >= AFULL_L);
    end
  end

  // Storage array with registered read port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem_q[wr_ptr_q] <= wr_data;
    if (rd_issue_s) ram_rd_q <= mem_q[rd_ptr_q];
  end

  // Control and output-stage state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      ram_count_q <= ZERO_L;
      pend_q      <= 1'b0;
      occ_q       <= 2'd0;
      skid0_q     <= DATA_ZERO;
      skid1_q     <= DATA_ZERO;
      level_q     <= ZERO_L;
      wr_ready_q  <= 1'b1;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      pend_q      <= pend_d;
      occ_q       <= occ_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      level_q     <= level_d;
      wr_ready_q  <= wr_ready_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign rd_data     = skid0_q;
  assign rd_valid    = (occ_q != 2'd0);
  assign level       = level_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_ram_fifo_fwft.sv
// Scoreboard bench for ram_fifo_fwft (ADDR=4): directed fill/drain/stream/flush/reset
// sequences plus a random handshake run, checked by an independent negedge monitor.
module tb_ram_fifo_fwft;
  localparam int ADDR  = 4;
  localparam int DATA  = 10;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [DATA-1:0] wr_data = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [DATA-1:0] rd_data;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [ADDR:0]   level;
  logic            empty, full, almost_full;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA-1:0] exp_q[$];
  int cyc = 0;
  int pops = 0;
  int first_pop = -1;
  int last_pop = -1;
  bit mon_en = 1'b0;
  bit prev_hold = 1'b0;
  logic [DATA-1:0] prev_data = '0;

  ram_fifo_fwft #(.ADDR(ADDR), .DATA(DATA), .AFULL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .level(level), .empty(empty), .full(full), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (exp_q.size() == 0 && !rd_valid) break;
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: flags against the model occupancy, pops against the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else if (mon_en) begin
      chk("level",       32'(level),       32'(exp_q.size()));
      chk("empty",       32'(empty),       32'(exp_q.size() == 0));
      chk("full",        32'(full),        32'(exp_q.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL));
      chk("wr_ready",    32'(wr_ready),    32'(exp_q.size() != DEPTH));
      if (prev_hold) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data",  32'(rd_data),  32'(prev_data));
      end
      if (flush) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) chk("pop_when_empty", 32'(rd_valid), 32'd0);
          else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
        if (wr_valid && wr_ready) exp_q.push_back(wr_data);
        prev_hold = rd_valid && !rd_ready;
        prev_data = rd_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int n_wr;
    int guard;

    // Reset values
    repeat (2) tick();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_afull",    32'(almost_full), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Fill to full with the consumer stalled, then offer a 17th word
    rd_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 10'(i);
      tick();
    end
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    wr_data = 10'h3FF;
    repeat (3) tick();
    wr_valid = 1'b0;
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_afull", 32'(almost_full), 32'd1);
    chk("fill_head",  32'(rd_data), 32'h001);
    chk("fill_valid", 32'(rd_valid), 32'd1);

    // Drain from full: 16 pops on consecutive cycles
    p0 = pops;
    first_pop = -1;
    rd_ready = 1'b1;
    repeat (16) tick();
    chk("drain_pops",   32'(pops - p0), 32'd16);
    chk("drain_span",   32'(last_pop - first_pop), 32'd15);
    chk("drain_empty",  32'(empty), 32'd1);
    chk("drain_level",  32'(level), 32'd0);

    // Continuous stream of 100 counting words
    p0 = pops;
    first_pop = -1;
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1'b1;
      wr_data  = 10'(i + 32'h40);
      tick();
    end
    wr_valid = 1'b0;
    wait_drain(50);
    chk("stream_pops", 32'(pops - p0), 32'd100);
    chk("stream_span", 32'(last_pop - first_pop), 32'd99);

    // Random handshakes on both sides
    n_wr = 0;
    guard = 0;
    while (n_wr < 2000 && guard < 20000) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      wr_data  = 10'($urandom);
      #0;
      if (wr_valid && wr_ready) n_wr++;
      tick();
      guard++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    chk("rand_written", 32'(n_wr), 32'd2000);
    wait_drain(100);

    // Flush together with a write and a pop
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 10'(i + 32'h100);
      tick();
    end
    wr_data  = 10'h3C3;
    rd_ready = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("flush_level",    32'(level),    32'd0);
    chk("flush_empty",    32'(empty),    32'd1);
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
    chk("flush_wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 10'h2AA;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("lat_early_valid", 32'(rd_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(rd_valid), 32'd1);
    chk("lat_data",  32'(rd_data),  32'h2AA);
    rd_ready = 1'b1;
    wait_drain(10);
    rd_ready = 1'b0;

    // Asynchronous reset mid-stream at level 9
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 10'(i + 32'h200);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    chk("pre_rst_level", 32'(level), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_data",  32'(rd_data),  32'd0);
    chk("arst_wr_ready", 32'(wr_ready), 32'd1);
    chk("arst_level",    32'(level),    32'd0);
    chk("arst_empty",    32'(empty),    32'd1);
    chk("arst_full",     32'(full),     32'd0);
    chk("arst_afull",    32'(almost_full), 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 10'h155;
    tick();
    wr_valid = 1'b0;
    p0 = pops;
    rd_ready = 1'b1;
    wait_drain(10);
    chk("post_rst_pops", 32'(pops - p0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
